// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Owns the CPU FSM state register and walks the combinational control_unit
//   through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. Adds run/single-step
//   control, memory wait-state stalling, halt latching, a memory watchdog and
//   a retired-instruction counter.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   next_state   in   [2:0] combinational next state from control_unit
//   halt         in   halt request from control_unit
//   run          in   1 = free-run, 0 = single-step
//   step         in   one-cycle pulse, starts one instruction from IDLE
//   mem_ready    in   memory completes its handshake this cycle
//   state        out  [2:0] registered FSM state, fed to control_unit
//   stall        out  combinational memory wait state
//   we_en        out  combinational datapath write-enable qualifier
//   running      out  registered, state is FETCH..WRITEBACK
//   halted       out  registered, state is HALT_STATE
//   error        out  registered sticky fault flag
//   instr_count  out  [CNT_W-1:0] retired-instruction count (wraps)
module cpu_sequencer #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       next_state,
    input  logic             halt,
    input  logic             run,
    input  logic             step,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             stall,
    output logic             we_en,
    output logic             running,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH      = 3'b000,
        DECODE     = 3'b001,
        EXECUTE    = 3'b010,
        MEMORY     = 3'b011,
        WRITEBACK  = 3'b100,
        HALT_STATE = 3'b101,
        IDLE       = 3'b110,
        INVALID    = 3'b111
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt;
    logic       active;
    logic       wd_expire;
    logic       err_set;
    logic       retire;

    assign state  = state_q;
    assign active = (state_q inside {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK});

    // Only the registered state feeds these, never next_state, so the
    // state -> control_unit -> next_state loop stays broken by the register.
    assign stall     = (state_q == FETCH || state_q == MEMORY) && !mem_ready;
    assign we_en     = active && !stall;
    assign wd_expire = stall && (wait_cnt == WAIT_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d = state_q;
        err_set = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run || step) state_d = FETCH;
            end
            HALT_STATE: ; // terminal until reset
            FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK: begin
                if (next_state == 3'b111) begin
                    state_d = HALT_STATE;
                    err_set = 1'b1;
                end else if (wd_expire) begin
                    state_d = HALT_STATE;
                    err_set = 1'b1;
                end else if (halt && !stall) begin
                    state_d = HALT_STATE;
                end else if (stall) begin
                    state_d = state_q;
                end else if (next_state == 3'b000) begin
                    retire  = 1'b1;
                    state_d = run ? FETCH : IDLE;
                end else begin
                    state_d = state_t'(next_state);
                end
            end
            default: begin
                // An illegal encoding in the register is treated as a fault.
                state_d = HALT_STATE;
                err_set = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            error       <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
            wait_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            error   <= error | err_set;
            // Decoded from state_d so the flags line up with state.
            running <= (state_d inside {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK});
            halted  <= (state_d == HALT_STATE);
            if (retire) instr_count <= instr_count + CNT_W'(1);
            // Expiry forces HALT_STATE, so the counter never passes WAIT_LAST+1.
            wait_cnt <= stall ? wait_cnt + 8'd1 : 8'd0;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//   Directed stimulus with hand-computed expectations. The stimulus process
//   pushes the expected per-cycle outputs into a queue; an independent
//   monitor pops one entry per cycle on the falling edge and compares.
module tb_cpu_sequencer;

    localparam logic [2:0] F = 3'b000, D = 3'b001, E = 3'b010, M = 3'b011,
                           W = 3'b100, H = 3'b101, I = 3'b110, X = 3'b111;

    typedef struct packed {
        logic [2:0]  st;
        logic        stall;
        logic        we;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  next_state;
    logic        halt, run, step, mem_ready;
    logic [2:0]  state;
    logic        stall, we_en, running, halted, error;
    logic [15:0] instr_count;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    cpu_sequencer #(.MAX_WAIT(15), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .next_state (next_state),
        .halt       (halt),
        .run        (run),
        .step       (step),
        .mem_ready  (mem_ready),
        .state      (state),
        .stall      (stall),
        .we_en      (we_en),
        .running    (running),
        .halted     (halted),
        .error      (error),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic exp_run, exp_halt;
            e        = exp_q.pop_front();
            exp_run  = (e.st <= W);
            exp_halt = (e.st == H);
            checks++;
            if (state !== e.st || stall !== e.stall || we_en !== e.we ||
                running !== exp_run || halted !== exp_halt ||
                error !== e.err || instr_count !== e.cnt) begin
                errors++;
                $display("FAIL cycle%0d: got st=%b stall=%b we=%b run=%b halt=%b err=%b cnt=%0d, want st=%b stall=%b we=%b run=%b halt=%b err=%b cnt=%0d",
                         cyc_no, state, stall, we_en, running, halted, error, instr_count,
                         e.st, e.stall, e.we, exp_run, exp_halt, e.err, e.cnt);
            end
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be this cycle.
    task automatic cyc(input logic rn, input logic [2:0] ns, input logic h,
                       input logic r, input logic s, input logic mr,
                       input logic [2:0] es, input logic est, input logic ewe,
                       input logic eerr, input logic [15:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        cyc_no++;
        reset_n    = rn;
        next_state = ns;
        halt       = h;
        run        = r;
        step       = s;
        mem_ready  = mr;
        e.st = es; e.stall = est; e.we = ewe; e.err = eerr; e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    initial begin
        reset_n = 1'b0; next_state = F; halt = 1'b0; run = 1'b0;
        step = 1'b0; mem_ready = 1'b1;

        // Reset state, then 5 idle cycles with run=0.
        cyc(0, F, 0, 0, 0, 1, I, 0, 0, 0, 0);
        cyc(1, F, 0, 0, 0, 1, I, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, F, 0, 0, 0, 1, I, 0, 0, 0, 0);

        // Free-run: IDLE -> FETCH in one cycle, then 4 x (F,D,E).
        cyc(1, F, 0, 1, 0, 1, I, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, D, 0, 1, 0, 1, F, 0, 1, 0, 16'(i));
            cyc(1, E, 0, 1, 0, 1, D, 0, 1, 0, 16'(i));
            cyc(1, F, 0, 1, 0, 1, E, 0, 1, 0, 16'(i));
        end

        // Three wait states in FETCH, then finish and drop to IDLE (run=0).
        for (int i = 0; i < 3; i++) cyc(1, D, 0, 1, 0, 0, F, 1, 0, 0, 4);
        cyc(1, D, 0, 1, 0, 1, F, 0, 1, 0, 4);
        cyc(1, E, 0, 1, 0, 1, D, 0, 1, 0, 4);
        cyc(1, F, 0, 0, 0, 1, E, 0, 1, 0, 4);

        // Single step; a second step during DECODE is ignored and not queued.
        cyc(1, F, 0, 0, 0, 1, I, 0, 0, 0, 5);
        cyc(1, F, 0, 0, 1, 1, I, 0, 0, 0, 5);
        cyc(1, D, 0, 0, 0, 1, F, 0, 1, 0, 5);
        cyc(1, E, 0, 0, 1, 1, D, 0, 1, 0, 5);
        cyc(1, F, 0, 0, 0, 1, E, 0, 1, 0, 5);
        cyc(1, F, 0, 0, 0, 1, I, 0, 0, 0, 6);
        cyc(1, F, 0, 0, 0, 1, I, 0, 0, 0, 6);

        // Halt with stall (stall wins), then halt with retire in EXECUTE.
        cyc(1, F, 0, 1, 0, 1, I, 0, 0, 0, 6);
        cyc(1, D, 1, 1, 0, 0, F, 1, 0, 0, 6);
        cyc(1, D, 0, 1, 0, 1, F, 0, 1, 0, 6);
        cyc(1, E, 0, 1, 0, 1, D, 0, 1, 0, 6);
        cyc(1, F, 1, 1, 0, 1, E, 0, 1, 0, 6);
        for (int i = 0; i < 3; i++) cyc(1, F, 0, 1, 1, 1, H, 0, 0, 0, 6);

        // Reset out of HALT clears the count; then reset mid-EXECUTE.
        cyc(0, F, 0, 0, 0, 1, I, 0, 0, 0, 0);
        cyc(1, F, 0, 1, 0, 1, I, 0, 0, 0, 0);
        cyc(1, D, 0, 1, 0, 1, F, 0, 1, 0, 0);
        cyc(1, E, 0, 1, 0, 1, D, 0, 1, 0, 0);
        cyc(0, M, 0, 1, 0, 1, I, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, F, 0, 0, 0, 1, I, 0, 0, 0, 0);

        // Watchdog: 15 stalled cycles in MEMORY -> HALT with error.
        cyc(1, F, 0, 1, 0, 1, I, 0, 0, 0, 0);
        cyc(1, D, 0, 1, 0, 1, F, 0, 1, 0, 0);
        cyc(1, E, 0, 1, 0, 1, D, 0, 1, 0, 0);
        cyc(1, M, 0, 1, 0, 1, E, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) cyc(1, W, 0, 1, 0, 0, M, 1, 0, 0, 0);
        cyc(1, W, 0, 1, 0, 1, H, 0, 0, 1, 0);
        cyc(1, W, 0, 1, 1, 1, H, 0, 0, 1, 0);

        // Invalid next_state in DECODE -> HALT with error on the next edge.
        cyc(0, F, 0, 0, 0, 1, I, 0, 0, 0, 0);
        cyc(1, F, 0, 1, 0, 1, I, 0, 0, 0, 0);
        cyc(1, D, 0, 1, 0, 1, F, 0, 1, 0, 0);
        cyc(1, X, 0, 1, 0, 1, D, 0, 1, 0, 0);
        cyc(1, F, 0, 1, 0, 1, H, 0, 0, 1, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
